// File: rtl/am_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am_pkg
//  Description : Shared types and sizing helpers for the associative-memory
//                query engine. Holds the engine state encoding and the
//                functions that derive segment count, similarity width and
//                class-index width from the top-level parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package am_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        SELECT  = 2'd2,
        DONE    = 2'd3
    } am_state_e;

    // Number of SEG_W-wide slices needed to cover the hypervector.
    function automatic int calc_num_segs(input int hv_dim, input int seg_w);
        return (hv_dim + seg_w - 1) / seg_w;
    endfunction

    // Width able to hold any overlap count 0..hv_dim.
    function automatic int calc_sim_w(input int hv_dim);
        return $clog2(hv_dim + 1);
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : am_pkg
`default_nettype wire

// File: rtl/am_seg_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : am_seg_popcount
//  Description : Combinational popcount of one SEG_W-bit segment, built as a
//                balanced binary adder tree. The leaf level is rounded up to
//                a power of two with zero leaves.
//  Ports       : bits_i   [SEG_W-1:0]           segment to count
//                count_o  [$clog2(SEG_W+1)-1:0] number of ones in bits_i
//  Revision    : 1.0  initial release
// ============================================================================
module am_seg_popcount #(
    parameter int SEG_W = 500,
    localparam int CNT_W = $clog2(SEG_W + 1)
) (
    input  logic [SEG_W-1:0] bits_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int LEVELS = $clog2(SEG_W);
    localparam int LEAVES = 1 << LEVELS;

    // Level 0 holds the leaves; level l has LEAVES >> l partial sums.
    generate
        for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
            localparam int N = LEAVES >> l;
            logic [CNT_W-1:0] sum [N];

            if (l == 0) begin : g_leaf
                for (genvar i = 0; i < N; i++) begin : g_bit
                    if (i < SEG_W) begin : g_used
                        assign sum[i] = CNT_W'(bits_i[i]);
                    end else begin : g_pad
                        assign sum[i] = '0;
                    end
                end
            end else begin : g_add
                for (genvar i = 0; i < N; i++) begin : g_node
                    assign sum[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
                end
            end
        end
    endgenerate

    assign count_o = g_lvl[LEVELS].sum[0];

endmodule : am_seg_popcount
`default_nettype wire

// File: rtl/am_query_engine.sv
`default_nettype none
// ============================================================================
//  Module      : am_query_engine
//  Description : Associative-memory search. Accepts one query hypervector,
//                accumulates its overlap with every class hypervector one
//                segment per cycle, scans the totals one class per cycle for
//                the argmax and runner-up, presents the result over a
//                valid/ready handshake and keeps a saturating accuracy tally.
//  Ports       : clk, rst            clock, async active-high reset
//                class_hvs           class c at [c*HV_DIM +: HV_DIM]
//                in_valid/in_ready   query handshake
//                query_hv/query_label query and its ground-truth class
//                out_valid/out_ready result handshake
//                class_inference     argmax class
//                best_sim, margin    best overlap and lead over runner-up
//                clear_tally         synchronous clear of the tally
//                num_correct/num_total  accuracy tally
//  Revision    : 1.0  initial release
// ============================================================================
module am_query_engine
    import am_pkg::*;
#(
    parameter int HV_DIM      = 5000,
    parameter int SEG_W       = 500,
    parameter int NUM_CLASSES = 26,
    parameter int TALLY_W     = 11,
    localparam int NUM_SEGS   = calc_num_segs(HV_DIM, SEG_W),
    localparam int SIM_W      = calc_sim_w(HV_DIM),
    localparam int CLS_W      = calc_idx_w(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLASSES*HV_DIM-1:0] class_hvs,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [HV_DIM-1:0]             query_hv,
    input  logic [CLS_W-1:0]              query_label,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CLS_W-1:0]              class_inference,
    output logic [SIM_W-1:0]              best_sim,
    output logic [SIM_W-1:0]              margin,
    input  logic                          clear_tally,
    output logic [TALLY_W-1:0]            num_correct,
    output logic [TALLY_W-1:0]            num_total
);

    localparam int SEG_IDX_W = calc_idx_w(NUM_SEGS);
    localparam int PAD_DIM   = NUM_SEGS * SEG_W;
    localparam int SEG_CNT_W = $clog2(SEG_W + 1);

    am_state_e              state_q, state_d;
    logic [HV_DIM-1:0]      query_q;
    logic [CLS_W-1:0]       label_q;
    logic [SEG_IDX_W-1:0]   seg_idx_q;
    logic [CLS_W-1:0]       scan_idx_q;
    logic [SIM_W-1:0]       best_q, second_q;
    logic [CLS_W-1:0]       arg_q;
    logic [CLS_W-1:0]       cls_out_q;
    logic [SIM_W-1:0]       best_sim_q, margin_q;
    logic [TALLY_W-1:0]     num_correct_q, num_total_q;

    logic                   w_accept, w_deliver, w_last_seg, w_last_cls;
    logic [PAD_DIM-1:0]     w_q_pad;
    logic [SEG_W-1:0]       w_q_segs [NUM_SEGS];
    logic [SEG_W-1:0]       w_q_seg;
    logic [SIM_W-1:0]       w_acc [NUM_CLASSES];
    logic [SIM_W-1:0]       w_cur;
    logic [SIM_W-1:0]       best_d, second_d;
    logic [CLS_W-1:0]       arg_d;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign w_accept   = in_valid && (state_q == IDLE);
    assign w_deliver  = out_ready && (state_q == DONE);
    assign w_last_seg = (seg_idx_q == SEG_IDX_W'(NUM_SEGS - 1));
    assign w_last_cls = (scan_idx_q == CLS_W'(NUM_CLASSES - 1));

    // Zero-extending to a whole number of segments makes the tail of the
    // last segment contribute nothing to any overlap count.
    assign w_q_pad = PAD_DIM'(query_q);

    generate
        for (genvar s = 0; s < NUM_SEGS; s++) begin : g_qseg
            assign w_q_segs[s] = w_q_pad[s*SEG_W +: SEG_W];
        end
    endgenerate

    assign w_q_seg = w_q_segs[seg_idx_q];

    // One overlap counter and accumulator per class.
    generate
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
            logic [PAD_DIM-1:0]   cls_pad;
            logic [SEG_W-1:0]     cls_segs [NUM_SEGS];
            logic [SEG_W-1:0]     and_seg;
            logic [SEG_CNT_W-1:0] seg_cnt;
            logic [SIM_W-1:0]     acc_q;

            assign cls_pad = PAD_DIM'(class_hvs[c*HV_DIM +: HV_DIM]);

            for (genvar s = 0; s < NUM_SEGS; s++) begin : g_cseg
                assign cls_segs[s] = cls_pad[s*SEG_W +: SEG_W];
            end

            assign and_seg = w_q_seg & cls_segs[seg_idx_q];

            am_seg_popcount #(
                .SEG_W (SEG_W)
            ) u_popcount (
                .bits_i  (and_seg),
                .count_o (seg_cnt)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (w_accept) begin
                    acc_q <= '0;
                end else if (state_q == COMPARE) begin
                    acc_q <= acc_q + SIM_W'(seg_cnt);
                end
            end

            assign w_acc[c] = acc_q;
        end
    endgenerate

    // Running argmax / runner-up update for the class under scan. Strict
    // comparisons keep the lower index on ties.
    assign w_cur = w_acc[scan_idx_q];

    always_comb begin
        best_d   = best_q;
        second_d = second_q;
        arg_d    = arg_q;
        if (w_cur > best_q) begin
            second_d = best_q;
            best_d   = w_cur;
            arg_d    = scan_idx_q;
        end else if (w_cur > second_q) begin
            second_d = w_cur;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept)   state_d = COMPARE;
            COMPARE: if (w_last_seg) state_d = SELECT;
            SELECT:  if (w_last_cls) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Query latch, sequencing indices, scan registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            query_q    <= '0;
            label_q    <= '0;
            seg_idx_q  <= '0;
            scan_idx_q <= '0;
            best_q     <= '0;
            second_q   <= '0;
            arg_q      <= '0;
            cls_out_q  <= '0;
            best_sim_q <= '0;
            margin_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        query_q    <= query_hv;
                        label_q    <= query_label;
                        seg_idx_q  <= '0;
                        scan_idx_q <= '0;
                        best_q     <= '0;
                        second_q   <= '0;
                        arg_q      <= '0;
                    end
                end
                COMPARE: begin
                    if (!w_last_seg) begin
                        seg_idx_q <= seg_idx_q + 1'b1;
                    end
                end
                SELECT: begin
                    best_q   <= best_d;
                    second_q <= second_d;
                    arg_q    <= arg_d;
                    if (w_last_cls) begin
                        // Results are published from the final scan step so
                        // they are valid on the same edge that enters DONE.
                        cls_out_q  <= arg_d;
                        best_sim_q <= best_d;
                        margin_q   <= best_d - second_d;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accuracy tally. A clear on the delivery edge suppresses that count.
    // Out-of-range labels can never equal an inferred class, so they only
    // reach num_total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_correct_q <= '0;
            num_total_q   <= '0;
        end else if (clear_tally) begin
            num_correct_q <= '0;
            num_total_q   <= '0;
        end else if (w_deliver) begin
            if (num_total_q != '1) begin
                num_total_q <= num_total_q + 1'b1;
            end
            if ((cls_out_q == label_q) && (num_correct_q != '1)) begin
                num_correct_q <= num_correct_q + 1'b1;
            end
        end
    end

    assign class_inference = cls_out_q;
    assign best_sim        = best_sim_q;
    assign margin          = margin_q;
    assign num_correct     = num_correct_q;
    assign num_total       = num_total_q;

endmodule : am_query_engine
`default_nettype wire

// File: tb/tb_am_query_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_query_engine
//  Description : Directed self-checking bench for am_query_engine. Main
//                instance: HV_DIM=16, SEG_W=4, NUM_CLASSES=4, TALLY_W=4.
//                Second instance: HV_DIM=10, SEG_W=4 (zero-padded tail).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_am_query_engine;

    logic clk;
    logic rst;

    // Main instance signals
    logic [63:0] class_hvs;
    logic        in_valid, in_ready;
    logic [15:0] query_hv;
    logic [1:0]  query_label;
    logic        out_valid, out_ready;
    logic [1:0]  class_inference;
    logic [4:0]  best_sim, margin;
    logic        clear_tally;
    logic [3:0]  num_correct, num_total;

    // Padded instance signals
    logic [39:0] p_class_hvs;
    logic        p_in_valid, p_in_ready;
    logic [9:0]  p_query_hv;
    logic [1:0]  p_query_label;
    logic        p_out_valid, p_out_ready;
    logic [1:0]  p_class_inference;
    logic [3:0]  p_best_sim, p_margin;
    logic        p_clear_tally;
    logic [3:0]  p_num_correct, p_num_total;

    int n_assert = 0;
    int n_fail   = 0;

    am_query_engine #(
        .HV_DIM(16), .SEG_W(4), .NUM_CLASSES(4), .TALLY_W(4)
    ) dut (
        .clk(clk), .rst(rst), .class_hvs(class_hvs),
        .in_valid(in_valid), .in_ready(in_ready),
        .query_hv(query_hv), .query_label(query_label),
        .out_valid(out_valid), .out_ready(out_ready),
        .class_inference(class_inference), .best_sim(best_sim), .margin(margin),
        .clear_tally(clear_tally), .num_correct(num_correct), .num_total(num_total)
    );

    am_query_engine #(
        .HV_DIM(10), .SEG_W(4), .NUM_CLASSES(4), .TALLY_W(4)
    ) dut_pad (
        .clk(clk), .rst(rst), .class_hvs(p_class_hvs),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .query_hv(p_query_hv), .query_label(p_query_label),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .class_inference(p_class_inference), .best_sim(p_best_sim), .margin(p_margin),
        .clear_tally(p_clear_tally), .num_correct(p_num_correct), .num_total(p_num_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a query on the main instance; returns #1 after the accept edge.
    task automatic start_query(input logic [63:0] hvs, input logic [15:0] q,
                               input logic [1:0] lbl, input bit keep_valid);
        class_hvs   = hvs;
        query_hv    = q;
        query_label = lbl;
        in_valid    = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        if (!keep_valid) in_valid = 1'b0;
        check("in_ready_busy", 32'(in_ready), 32'd0);
    endtask

    // Count edges after the accept edge until out_valid, with a bound.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic handshake(input bit clr);
        out_ready   = 1'b1;
        clear_tally = clr;
        tick();
        out_ready   = 1'b0;
        clear_tally = 1'b0;
    endtask

    initial begin
        int lat;

        rst = 1'b1;
        class_hvs = '0; in_valid = 1'b0; query_hv = '0; query_label = '0;
        out_ready = 1'b0; clear_tally = 1'b0;
        p_class_hvs = '0; p_in_valid = 1'b0; p_query_hv = '0; p_query_label = '0;
        p_out_ready = 1'b0; p_clear_tally = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset / idle state
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_class",     32'(class_inference), 32'd0);
        check("rst_best_sim",  32'(best_sim), 32'd0);
        check("rst_margin",    32'(margin), 32'd0);
        check("rst_correct",   32'(num_correct), 32'd0);
        check("rst_total",     32'(num_total), 32'd0);

        // Graded classes: class c has c+1 ones per 4-bit segment.
        start_query(64'hFFFF_7777_3333_1111, 16'hFFFF, 2'd3, 1'b0);
        wait_done("latency_graded", 8);
        check("graded_class",  32'(class_inference), 32'd3);
        check("graded_best",   32'(best_sim), 32'd16);
        check("graded_margin", 32'(margin), 32'd4);
        handshake(1'b0);
        check("graded_correct",  32'(num_correct), 32'd1);
        check("graded_total",    32'(num_total), 32'd1);
        check("graded_idle",     32'(out_valid), 32'd0);
        check("graded_held_cls", 32'(class_inference), 32'd3);

        // Tie between class 0 and class 2, with backpressure and in_valid held.
        start_query(64'h0000_000F_0000_000F, 16'h00FF, 2'd2, 1'b1);
        check("tie_prev_result_held", 32'(class_inference), 32'd3);
        query_hv = 16'hFFFF;
        wait_done("latency_tie", 8);
        check("tie_class",  32'(class_inference), 32'd0);
        check("tie_best",   32'(best_sim), 32'd4);
        check("tie_margin", 32'(margin), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready), 32'd0);
            check("bp_class",     32'(class_inference), 32'd0);
            check("bp_best",      32'(best_sim), 32'd4);
            check("bp_total",     32'(num_total), 32'd1);
        end
        handshake(1'b0);
        in_valid = 1'b0;
        check("bp_release_total",   32'(num_total), 32'd2);
        check("bp_release_correct", 32'(num_correct), 32'd1);
        check("bp_release_ready",   32'(in_ready), 32'd1);
        tick();
        check("bp_no_second_accept", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of COMPARE.
        start_query(64'hFFFF_7777_3333_1111, 16'hFFFF, 2'd3, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready",  32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_class",     32'(class_inference), 32'd0);
        check("arst_total",     32'(num_total), 32'd0);
        check("arst_correct",   32'(num_correct), 32'd0);
        #2 rst = 1'b0;
        tick();

        // Sixteen correct queries saturate a 4-bit tally at 15.
        for (int i = 0; i < 16; i++) begin
            start_query(64'hFFFF_7777_3333_1111, 16'hFFFF, 2'd3, 1'b0);
            wait_done("latency_sat", 8);
            handshake(1'b0);
        end
        check("sat_correct", 32'(num_correct), 32'd15);
        check("sat_total",   32'(num_total), 32'd15);

        // Clear on the delivery edge wins; that result is not counted.
        start_query(64'hFFFF_7777_3333_1111, 16'hFFFF, 2'd3, 1'b0);
        wait_done("latency_clr", 8);
        handshake(1'b1);
        check("clr_correct", 32'(num_correct), 32'd0);
        check("clr_total",   32'(num_total), 32'd0);
        check("clr_idle",    32'(in_ready), 32'd1);

        // Padded configuration: HV_DIM=10 in three 4-bit segments.
        p_class_hvs   = {10'h000, 10'h000, 10'h3FF, 10'h000};
        p_query_hv    = 10'h3FF;
        p_query_label = 2'd1;
        p_in_valid    = 1'b1;
        check("pad_ready_before", 32'(p_in_ready), 32'd1);
        tick();
        p_in_valid = 1'b0;
        lat = 0;
        while (!p_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("pad_latency", 32'(lat), 32'd7);
        check("pad_class",   32'(p_class_inference), 32'd1);
        check("pad_best",    32'(p_best_sim), 32'd10);
        check("pad_margin",  32'(p_margin), 32'd10);
        p_out_ready = 1'b1;
        tick();
        p_out_ready = 1'b0;
        check("pad_correct", 32'(p_num_correct), 32'd1);
        check("pad_total",   32'(p_num_total), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_am_query_engine
`default_nettype wire
